shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle driver for the datapath's single-step shifter operation. It accepts a 16-bit operand, a 2-bit shift op and a shift amount. It then applies the same 1-bit shift op once per clock, `amount` times, and reports the result with a done pulse. This gives the datapath shifts of 0..15 positions without a barrel shifter, using the same op encoding as the single-step shifter.

Parameters:
WIDTH, 16, operand/result width in bits
AMT_W, 4, width of the shift-amount field (max amount 2^AMT_W-1)

Ports:
clk  in  1  single clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  request; sampled on the rising edge of clk
in  in  WIDTH  operand, captured when start is accepted
shift  in  2  op, captured on accept: 00 pass, 01 LSL by 1, 10 LSR by 1 (MSB<-0), 11 ASR by 1 (MSB kept)
amount  in  AMT_W  number of steps, captured on accept
busy  out  1  high while in RUN
done  out  1  one-cycle pulse: result valid
sout  out  WIDTH  result register; holds its value until the next accepted start

Behaviour:
- Reset, asynchronous on reset_n=0:
  - state=IDLE; busy=0; done=0; sout=0; step counter=0.
  - Reset asserted mid-RUN aborts the operation. No done pulse follows.
- Single-step function f(a):
  - 00 -> a
  - 01 -> {a[W-2:0],0}
  - 10 -> {0,a[W-1:1]}
  - 11 -> {a[W-1],a[W-1:1]}
  - Bits shifted out are discarded. No wrap-around.
- States: IDLE, RUN, DONE.
- Accept rule: start is accepted only in IDLE or DONE.
  - An accepted start captures in into sout, and captures shift and amount.
  - start during RUN is ignored, with no effect on the operation or outputs.
- IDLE/DONE with start=1:
  - amount==0 -> DONE (sout=in unchanged).
  - Otherwise -> RUN with count=amount.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: -> IDLE.
- RUN, each edge:
  - sout<=f(sout); count<=count-1.
  - When count==1 before the edge -> DONE.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE), so it is a one-cycle pulse unless a back-to-back start from DONE re-enters DONE (amount 0).
- Latency: with start accepted at edge E0, done is high in the cycle after edge E(amount). amount=0 means done is high in the cycle right after E0.
- Throughput: start may be asserted while done=1. Back-to-back ops have no idle bubble.
- sout is a registered output and is stable during DONE and IDLE. During RUN it shows intermediate values.
- amount = 2^AMT_W-1 (15) is legal:
  - LSR/LSL of any operand gives 0.
  - ASR gives all copies of the original MSB.

Optional Feature:
Macro SHIFT_COUT_EN.
- Defined:
  - Adds output port cout (1 bit): the last bit shifted out.
  - For 01 it takes a[W-1]; for 10/11 it takes a[0], captured on each RUN step.
  - Cleared to 0 on accepted start and on reset. Stays 0 for op 00 or amount 0.
  - Valid while done=1 and held until the next accepted start.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. in=16'h0005, shift=00, amount=3, start pulse -> busy high 3 cycles; done pulse in the cycle after the 3rd RUN edge; sout=16'h0005.
2. in=16'h0002, shift=01, amount=3 -> sout=16'h0010 at done. Repeat with amount=15 -> sout=16'h0000.
3. in=16'hE000, shift=11, amount=4 -> sout=16'hFE00. in=16'h6000, shift=11, amount=1 -> sout=16'h3000 (MSB kept 0).
4. in=16'h8000, shift=10, amount=15 -> sout=16'h0001. amount=0 with in=16'h1234 -> done in the cycle right after the start edge, sout=16'h1234, busy never high.
5. Start amount=5 op=01 in=16'h0001, then pulse start with in=16'hFFFF at RUN cycle 2 -> second start ignored; sout=16'h0020. Then start again while done=1 (amount=1, op=10, in=16'h0004) -> accepted back-to-back; sout=16'h0002.
6. reset_n driven low mid-RUN -> busy, done and sout go to 0 immediately (asynchronously); no done pulse after release. With SHIFT_COUT_EN: in=16'h0003, op=10, amount=1 -> cout=1, sout=16'h0001; in=16'h4000, op=01, amount=2 -> cout=1, sout=16'h0000.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter driver: applies a 1-bit shift op `amount` times, one step per clock.
// Optional carry-out port enabled by defining SHIFT_COUT_EN.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout
`ifdef SHIFT_COUT_EN
    ,
    output logic             cout
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] count;
    logic [1:0]       op;
    logic             accept;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a, input logic [1:0] o);
        case (o)
            2'b01:   step = {a[WIDTH-2:0], 1'b0};
            2'b10:   step = {1'b0, a[WIDTH-1:1]};
            2'b11:   step = {a[WIDTH-1], a[WIDTH-1:1]};
            default: step = a;
        endcase
    endfunction

    // Starts arriving while RUN is in progress are dropped entirely.
    assign accept = start && (state != RUN);

    // NOTE: next-state is assigned a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = (amount == '0) ? DONE : RUN;
                else
                    state_nxt = IDLE;
            end
            RUN: begin
                if (count == AMT_W'(1))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, matching real hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            op    <= 2'b00;
            sout  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sout  <= in;
                op    <= shift;
                count <= amount;
            end else if (state == RUN) begin
                sout  <= step(sout, op);
                count <= count - AMT_W'(1);
            end
        end
    end

`ifdef SHIFT_COUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cout <= 1'b0;
        end else if (accept) begin
            cout <= 1'b0;
        end else if (state == RUN) begin
            case (op)
                2'b01:        cout <= sout[WIDTH-1];
                2'b10, 2'b11: cout <= sout[0];
                default:      cout <= 1'b0;
            endcase
        end
    end
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_shift_sequencer;

    localparam int W = 16;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic [1:0]   shift = 2'b00;
    logic [A-1:0] amount = '0;
    logic         busy, done;
    logic [W-1:0] sout;
`ifdef SHIFT_COUT_EN
    logic         cout;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .in      (din),
        .shift   (shift),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .sout    (sout)
`ifdef SHIFT_COUT_EN
        ,
        .cout    (cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result after k steps is the operand shifted by k positions.
    function automatic logic [W-1:0] shifted(input logic [W-1:0] a, input logic [1:0] o, input int k);
        logic signed [W-1:0] s;
        s = a;
        case (o)
            2'b01:   return a << k;
            2'b10:   return a >> k;
            2'b11:   return s >>> k;
            default: return a;
        endcase
    endfunction

    // Last bit shifted out after k steps, taken straight from the original operand.
    function automatic logic last_out(input logic [W-1:0] a, input logic [1:0] o, input int k);
        if (k == 0 || o == 2'b00) return 1'b0;
        if (o == 2'b01) return a[W-k];
        return a[k-1];
    endfunction

    logic [W-1:0] m_in = '0;
    logic [1:0]   m_op = 2'b00;
    int           m_k = 0;
    int           m_rem = 0;
    bit           m_done = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_in   <= '0;
            m_op   <= 2'b00;
            m_k    <= 0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else if (start && m_rem == 0) begin
            m_in   <= din;
            m_op   <= shift;
            m_k    <= 0;
            m_rem  <= int'(amount);
            m_done <= (amount == '0);
        end else if (m_rem > 0) begin
            m_k    <= m_k + 1;
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", {31'b0, busy}, {31'b0, (m_rem != 0)});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("sout", {16'b0, sout}, {16'b0, shifted(m_in, m_op, m_k)});
`ifdef SHIFT_COUT_EN
            check("cout", {31'b0, cout}, {31'b0, last_out(m_in, m_op, m_k)});
`endif
        end
    end

    // Called at a negedge after the accept edge; returns at the negedge where done is seen.
    task automatic wait_done(output int nbusy);
        int cyc;
        nbusy = 0;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; drives a one-cycle start and waits for the result.
    task automatic run_op(input logic [W-1:0] a, input logic [1:0] o, input logic [A-1:0] n,
                          output int nbusy);
        din = a; shift = o; amount = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nbusy);
    endtask

    int nb;

    initial begin
        #3 reset_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sout", {16'b0, sout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        // Pass op: value unchanged, busy exactly amount cycles.
        run_op(16'h0005, 2'b00, 4'd3, nb);
        check("t1_sout", {16'b0, sout}, 32'h0005);
        check("t1_busy_cycles", nb, 32'd3);

        @(negedge clk);
        run_op(16'h0002, 2'b01, 4'd3, nb);
        check("t2_lsl3", {16'b0, sout}, 32'h0010);
        @(negedge clk);
        run_op(16'h0002, 2'b01, 4'd15, nb);
        check("t2_lsl15", {16'b0, sout}, 32'h0000);

        @(negedge clk);
        run_op(16'hE000, 2'b11, 4'd4, nb);
        check("t3_asr4", {16'b0, sout}, 32'hFE00);
        @(negedge clk);
        run_op(16'h6000, 2'b11, 4'd1, nb);
        check("t3_asr1", {16'b0, sout}, 32'h3000);

        @(negedge clk);
        run_op(16'h8000, 2'b10, 4'd15, nb);
        check("t4_lsr15", {16'b0, sout}, 32'h0001);
        @(negedge clk);
        run_op(16'h1234, 2'b01, 4'd0, nb);
        check("t4_amt0_sout", {16'b0, sout}, 32'h1234);
        check("t4_amt0_busy", nb, 32'd0);
        @(negedge clk);
        check("t4_amt0_idle", {31'b0, done}, 32'd0);

        // Start during RUN is ignored, then a back-to-back start from DONE.
        din = 16'h0001; shift = 2'b01; amount = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        din = 16'hFFFF; shift = 2'b10; amount = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb);
        check("t5_ignored", {16'b0, sout}, 32'h0020);
        run_op(16'h0004, 2'b10, 4'd1, nb);
        check("t5_b2b_sout", {16'b0, sout}, 32'h0002);
        check("t5_b2b_busy", nb, 32'd1);

`ifdef SHIFT_COUT_EN
        @(negedge clk);
        run_op(16'h0003, 2'b10, 4'd1, nb);
        check("t6_cout_lsr", {31'b0, cout}, 32'd1);
        check("t6_sout_lsr", {16'b0, sout}, 32'h0001);
        @(negedge clk);
        run_op(16'h4000, 2'b01, 4'd2, nb);
        check("t6_cout_lsl", {31'b0, cout}, 32'd1);
        check("t6_sout_lsl", {16'b0, sout}, 32'h0000);
`endif

        // Asynchronous reset in the middle of a RUN aborts it.
        @(negedge clk);
        din = 16'h0001; shift = 2'b01; amount = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_done", {31'b0, done}, 32'd0);
        check("t6_rst_sout", {16'b0, sout}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("t6_no_done", {31'b0, done}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
